// File: rtl/video_stream_checker_if.sv
// AXI-Stream video handshake bundle: valid, SOF (tuser), EOL (tlast) and ready.
interface video_stream_checker_if;
  logic tvalid;
  logic tuser;
  logic tlast;
  logic tready;

  modport master (output tvalid, output tuser, output tlast, input tready);
  modport slave  (input tvalid, input tuser, input tlast, output tready);
endinterface

// File: rtl/video_stream_checker.sv
// AXI-Stream video sink: generates tready under a selectable back-pressure pattern
// and tracks frame framing, counting frames, SOF/EOL errors and valid timeouts.
module video_stream_checker #(
  parameter int          X_SIZE   = 1280,
  parameter int          Y_SIZE   = 720,
  parameter int          TIMEOUT  = 1000,
  parameter int          CNT_W    = 16,
  parameter logic [32:0] RND_SEED = 33'd1246504138
) (
  input  logic                       in_stream_aclk,
  input  logic                       periph_resetn,
  video_stream_checker_if.slave      in_stream,
  input  logic [1:0]                 ready_mode,
  input  logic                       stat_clear,
  output logic [CNT_W-1:0]           frame_count,
  output logic [CNT_W-1:0]           sof_err_count,
  output logic [CNT_W-1:0]           eol_err_count,
  output logic [CNT_W-1:0]           timeout_count,
  output logic                       err_flag,
  output logic [$clog2(X_SIZE)-1:0]  x_pos,
  output logic [$clog2(Y_SIZE)-1:0]  y_pos
);

  localparam int XW = $clog2(X_SIZE);
  localparam int YW = $clog2(Y_SIZE);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [XW-1:0] X_LAST    = XW'(X_SIZE - 1);
  localparam logic [YW-1:0] Y_LAST    = YW'(Y_SIZE - 1);
  localparam logic [TW-1:0] IDLE_LAST = TW'(TIMEOUT - 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic inc);
    return (inc && (c != '1)) ? c + CNT_W'(1) : c;
  endfunction

  logic [32:0]   prbs;
  logic          tready_r;
  logic [TW-1:0] idle_cnt;

  logic          beat, sof_exp, sof_err, frame_inc, eol_err, line_end, idle_hit;
  logic          x_last, ready_nxt;
  logic [XW-1:0] x_eff, x_nxt;
  logic [YW-1:0] y_eff, y_nxt;
  logic [32:0]   prbs_nxt;

  assign in_stream.tready = tready_r;

  // Beat decode: an SOF anywhere resynchronises the beat to word 0, line 0
  always_comb begin
    beat      = in_stream.tvalid & tready_r;
    sof_exp   = (x_pos == '0) && (y_pos == '0);
    sof_err   = beat & (sof_exp ? ~in_stream.tuser : in_stream.tuser);
    frame_inc = beat & in_stream.tuser;
    x_eff     = in_stream.tuser ? '0 : x_pos;
    y_eff     = in_stream.tuser ? '0 : y_pos;
    x_last    = (x_eff == X_LAST);
    eol_err   = beat & (x_last ^ in_stream.tlast);
    line_end  = x_last | in_stream.tlast;
    x_nxt     = line_end ? '0 : x_eff + XW'(1);
    y_nxt     = line_end ? ((y_eff == Y_LAST) ? '0 : y_eff + YW'(1)) : y_eff;
    idle_hit  = ~in_stream.tvalid & (idle_cnt == IDLE_LAST);
  end

  // Back-pressure pattern; the LFSR free-runs so switching into PRBS mode is seamless
  always_comb begin
    prbs_nxt = {prbs[31:0], prbs[32] ^ ~prbs[19]};
    case (ready_mode)
      2'd0:    ready_nxt = 1'b1;
      2'd1:    ready_nxt = prbs[32];
      2'd2:    ready_nxt = in_stream.tvalid & ~tready_r;
      default: ready_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge in_stream_aclk or negedge periph_resetn) begin
    if (!periph_resetn) begin
      prbs          <= RND_SEED;
      tready_r      <= 1'b0;
      idle_cnt      <= '0;
      x_pos         <= '0;
      y_pos         <= '0;
      frame_count   <= '0;
      sof_err_count <= '0;
      eol_err_count <= '0;
      timeout_count <= '0;
      err_flag      <= 1'b0;
    end else begin
      prbs     <= prbs_nxt;
      tready_r <= ready_nxt;
      idle_cnt <= (in_stream.tvalid | idle_hit) ? '0 : idle_cnt + TW'(1);
      if (beat) begin
        x_pos <= x_nxt;
        y_pos <= y_nxt;
      end
      // Clear has priority over any coincident increment
      if (stat_clear) begin
        frame_count   <= '0;
        sof_err_count <= '0;
        eol_err_count <= '0;
        timeout_count <= '0;
        err_flag      <= 1'b0;
      end else begin
        frame_count   <= sat_inc(frame_count, frame_inc);
        sof_err_count <= sat_inc(sof_err_count, sof_err);
        eol_err_count <= sat_inc(eol_err_count, eol_err);
        timeout_count <= sat_inc(timeout_count, idle_hit);
        err_flag      <= err_flag | sof_err | eol_err | idle_hit;
      end
    end
  end

endmodule

// File: tb/tb_video_stream_checker.sv
// Directed bench for video_stream_checker: table-driven framing vectors plus
// hand-written sequences for timeout, saturation, back-pressure modes and async reset.
module tb_video_stream_checker;

  localparam logic [32:0] SEED = 33'd1246504138;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] ready_mode = 2'd0;
  logic       stat_clear = 1'b0;
  logic [2:0] frame_count, sof_err_count, eol_err_count, timeout_count;
  logic       err_flag;
  logic [1:0] x_pos, y_pos;

  int n_chk  = 0;
  int n_fail = 0;

  video_stream_checker_if vif ();

  video_stream_checker #(
    .X_SIZE(4), .Y_SIZE(3), .TIMEOUT(8), .CNT_W(3), .RND_SEED(SEED)
  ) dut (
    .in_stream_aclk (clk),
    .periph_resetn  (rst_n),
    .in_stream      (vif),
    .ready_mode     (ready_mode),
    .stat_clear     (stat_clear),
    .frame_count    (frame_count),
    .sof_err_count  (sof_err_count),
    .eol_err_count  (eol_err_count),
    .timeout_count  (timeout_count),
    .err_flag       (err_flag),
    .x_pos          (x_pos),
    .y_pos          (y_pos)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected test completion");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    bit vld, sof, eol, clr;
    int ex, ey, ef, es, ee, er;
  } vec_t;

  vec_t vec[$];

  function automatic void add(bit vld, bit sof, bit eol, bit clr,
                              int ex, int ey, int ef, int es, int ee, int er);
    vec_t v;
    v.vld = vld; v.sof = sof; v.eol = eol; v.clr = clr;
    v.ex = ex; v.ey = ey; v.ef = ef; v.es = es; v.ee = ee; v.er = er;
    vec.push_back(v);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset(input logic [1:0] mode);
    rst_n = 1'b0;
    vif.tvalid = 1'b0; vif.tuser = 1'b0; vif.tlast = 1'b0;
    stat_clear = 1'b0;
    ready_mode = mode;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drive_beat(input bit sof, input bit eol);
    vif.tvalid = 1'b1; vif.tuser = sof; vif.tlast = eol;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [32:0] m;
    int beats, mism, first_bad;

    // Framing vectors: two clean frames, a no-beat row, a clear, then error cases
    for (int f = 1; f <= 2; f++)
      for (int y = 0; y < 3; y++)
        for (int x = 0; x < 4; x++)
          add(1, (x == 0 && y == 0), (x == 3), 0,
              (x == 3) ? 0 : x + 1, (x == 3) ? (y + 1) % 3 : y, f, 0, 0, 0);
    add(0, 1, 1, 0, 0, 0, 2, 0, 0, 0);
    add(0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    add(1, 1, 0, 0, 1, 0, 1, 0, 0, 0);
    add(1, 0, 0, 0, 2, 0, 1, 0, 0, 0);
    add(1, 0, 0, 0, 3, 0, 1, 0, 0, 0);
    add(1, 0, 1, 0, 0, 1, 1, 0, 0, 0);
    add(1, 0, 0, 0, 1, 1, 1, 0, 0, 0);
    add(1, 0, 0, 0, 2, 1, 1, 0, 0, 0);
    add(1, 0, 0, 0, 3, 1, 1, 0, 0, 0);
    add(1, 0, 0, 0, 0, 2, 1, 0, 1, 1);
    add(1, 0, 0, 0, 1, 2, 1, 0, 1, 1);
    add(1, 0, 0, 0, 2, 2, 1, 0, 1, 1);
    add(1, 0, 0, 0, 3, 2, 1, 0, 1, 1);
    add(1, 0, 1, 0, 0, 0, 1, 0, 1, 1);
    add(1, 1, 0, 0, 1, 0, 2, 0, 1, 1);
    add(1, 0, 0, 0, 2, 0, 2, 0, 1, 1);
    add(1, 0, 0, 0, 3, 0, 2, 0, 1, 1);
    add(1, 0, 1, 0, 0, 1, 2, 0, 1, 1);
    add(1, 0, 0, 0, 1, 1, 2, 0, 1, 1);
    add(1, 0, 0, 0, 2, 1, 2, 0, 1, 1);
    add(1, 1, 0, 0, 1, 0, 3, 1, 1, 1);
    add(1, 0, 0, 0, 2, 0, 3, 1, 1, 1);
    add(1, 1, 1, 0, 0, 1, 4, 2, 2, 1);
    add(1, 0, 1, 0, 0, 2, 4, 2, 3, 1);

    do_reset(2'd0);
    chk("rst_tready", vif.tready, 0);
    chk("rst_frame", frame_count, 0);
    chk("rst_x", x_pos, 0);
    chk("rst_y", y_pos, 0);
    chk("rst_err", err_flag, 0);
    @(posedge clk);
    @(negedge clk);
    chk("mode0_tready", vif.tready, 1);

    foreach (vec[i]) begin
      vif.tvalid = vec[i].vld; vif.tuser = vec[i].sof; vif.tlast = vec[i].eol;
      stat_clear = vec[i].clr;
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("vec%0d_x", i), x_pos, vec[i].ex);
      chk($sformatf("vec%0d_y", i), y_pos, vec[i].ey);
      chk($sformatf("vec%0d_frame", i), frame_count, vec[i].ef);
      chk($sformatf("vec%0d_sof", i), sof_err_count, vec[i].es);
      chk($sformatf("vec%0d_eol", i), eol_err_count, vec[i].ee);
      chk($sformatf("vec%0d_err", i), err_flag, vec[i].er);
    end
    vif.tvalid = 1'b0; stat_clear = 1'b0;

    // Timeouts every 8 idle cycles, clear, then saturation of a 3-bit counter
    do_reset(2'd0);
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("timeout_20", timeout_count, 2);
    chk("timeout_err", err_flag, 1);
    stat_clear = 1'b1;
    @(posedge clk);
    @(negedge clk);
    stat_clear = 1'b0;
    chk("clr_timeout", timeout_count, 0);
    chk("clr_err", err_flag, 0);
    chk("clr_frame", frame_count, 0);
    repeat (80) @(posedge clk);
    @(negedge clk);
    chk("timeout_sat", timeout_count, 7);

    // Ready-after-valid: alternating ready, one beat every two cycles
    do_reset(2'd2);
    vif.tvalid = 1'b1;
    beats = 0;
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("mode2_tready%0d", i), vif.tready, i % 2);
      if (vif.tready) beats++;
      @(posedge clk);
      @(negedge clk);
    end
    vif.tvalid = 1'b0;
    chk("mode2_beats", beats, 5);

    // PRBS ready against a reference LFSR
    do_reset(2'd1);
    m = SEED;
    mism = 0;
    first_bad = -1;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (vif.tready !== m[32]) begin
        mism++;
        if (first_bad < 0) first_bad = i;
      end
      m = {m[31:0], m[32] ^ ~m[19]};
    end
    chk("prbs_mismatches", mism, 0);
    if (mism != 0) $display("  first differing prbs cycle %0d", first_bad);

    // Asynchronous reset mid-line, then missing SOF on the first beat
    do_reset(2'd0);
    @(posedge clk);
    @(negedge clk);
    drive_beat(1, 0);
    drive_beat(0, 0);
    drive_beat(0, 0);
    drive_beat(0, 1);
    drive_beat(0, 0);
    drive_beat(0, 0);
    vif.tvalid = 1'b0; vif.tuser = 1'b0; vif.tlast = 1'b0;
    chk("pre_rst_x", x_pos, 2);
    chk("pre_rst_y", y_pos, 1);
    chk("pre_rst_frame", frame_count, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_x", x_pos, 0);
    chk("async_rst_y", y_pos, 0);
    chk("async_rst_frame", frame_count, 0);
    chk("async_rst_tready", vif.tready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    vif.tvalid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("post_rst_nobeat_x", x_pos, 0);
    @(posedge clk);
    @(negedge clk);
    vif.tvalid = 1'b0;
    chk("post_rst_sof_err", sof_err_count, 1);
    chk("post_rst_frame", frame_count, 0);
    chk("post_rst_x", x_pos, 1);
    chk("post_rst_err", err_flag, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
